// File: rtl/dualportram_be.sv
// Dual-port word RAM (one write, one read, one clock) with byte enables, a
// read-valid pipeline, selectable read-during-write policy and a zero-fill sequencer.
module dualportram_be #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 10,
  parameter int OUT_REG        = 0,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        length,
  output logic               busy,
  input  logic               clear,
  input  logic [DEPTH-1:0]   waddress,
  input  logic [WIDTH-1:0]   din,
  input  logic               we,
  input  logic [WIDTH/8-1:0] be,
  input  logic [DEPTH-1:0]   raddress,
  input  logic               re,
  output logic [WIDTH-1:0]   dout,
  output logic               rvalid
);

  localparam int NB = WIDTH / 8;
  localparam logic [DEPTH-1:0] LAST_ADDR = {DEPTH{1'b1}};

  if (WIDTH % 8 != 0) begin : g_width_chk
    $error("dualportram_be: WIDTH must be a multiple of 8");
  end

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t           r_state;
  logic             r_busy;
  logic [DEPTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_mem [0:(1<<DEPTH)-1];
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;

  logic             w_port_we;
  logic             w_rd_acc;
  logic             w_rdw_hit;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_rd_word;

  assign length    = 32'd1 << DEPTH;
  assign busy      = r_busy;
  assign w_port_we = reset && (r_state == ST_IDLE) && we;
  assign w_rd_acc  = (r_state == ST_IDLE) && re;
  assign w_rdw_hit = (RDW_NEW != 0) && we && (raddress == waddress);
  assign w_old     = r_mem[raddress];
  assign w_rd_word = w_rdw_hit ? w_merged : w_old;

  // byte-merged view of the word being written, used by the new-data bypass
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        w_merged[8*i +: 8] = din[8*i +: 8];
      end else begin
        w_merged[8*i +: 8] = w_old[8*i +: 8];
      end
    end
  end

  // array write port; the clear sequencer owns the array while busy
  always_ff @(posedge clk) begin
    if (reset && (r_state == ST_CLEAR)) begin
      r_mem[r_cnt] <= {WIDTH{1'b0}};
    end else if (w_port_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          r_mem[waddress][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  // clear sequencer: walks every address once, then hands the array back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_busy  <= (CLEAR_ON_RESET != 0);
      r_cnt   <= {DEPTH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= {DEPTH{1'b0}};
          end
        end
        ST_CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= {DEPTH{1'b0}};
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= {DEPTH{1'b0}};
        end
      endcase
    end
  end

  // first read stage: data only reloads on an accepted read, so it holds otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= {WIDTH{1'b0}};
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;

    // optional output stage, one cycle behind the first
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_s2_valid <= 1'b0;
        r_s2_data  <= {WIDTH{1'b0}};
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign dout   = r_s2_data;
    assign rvalid = r_s2_valid;
  end else begin : g_noreg
    assign dout   = r_s1_data;
    assign rvalid = r_s1_valid;
  end

endmodule

// File: tb/tb_dualportram_be.sv
// Bench for dualportram_be: two instances (latency 1/old-data and latency 2/new-data)
// driven by shared stimulus and compared against a word-array reference model.
module tb_dualportram_be;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [3:0]  waddress;
  logic [31:0] din;
  logic        we;
  logic [3:0]  be;
  logic [3:0]  raddress;
  logic        re;

  logic [31:0] length_a, length_b;
  logic        busy_a, busy_b;
  logic [31:0] dout_a, dout_b;
  logic        rvalid_a, rvalid_b;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_mem [0:15];
  logic        m_busy;
  int          m_cnt;
  logic [31:0] ma_dout, mb_dout, mb_s1d;
  logic        ma_rv, mb_rv, mb_s1v;

  dualportram_be #(.WIDTH(32), .DEPTH(4), .OUT_REG(0), .RDW_NEW(0), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(reset), .length(length_a), .busy(busy_a), .clear(clear),
    .waddress(waddress), .din(din), .we(we), .be(be), .raddress(raddress), .re(re),
    .dout(dout_a), .rvalid(rvalid_a));

  dualportram_be #(.WIDTH(32), .DEPTH(4), .OUT_REG(1), .RDW_NEW(1), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .reset(reset), .length(length_b), .busy(busy_b), .clear(clear),
    .waddress(waddress), .din(din), .we(we), .be(be), .raddress(raddress), .re(re),
    .dout(dout_b), .rvalid(rvalid_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b1;
    m_cnt   = 0;
    ma_dout = 32'h0; ma_rv = 1'b0;
    mb_dout = 32'h0; mb_rv = 1'b0;
    mb_s1d  = 32'h0; mb_s1v = 1'b0;
  endtask

  // one clock edge of the reference behaviour, applied to the current inputs
  task automatic model_edge();
    logic [31:0] old_w, new_w;
    if (mb_s1v) mb_dout = mb_s1d;
    mb_rv  = mb_s1v;
    mb_s1v = 1'b0;
    ma_rv  = 1'b0;
    if (m_busy) begin
      m_mem[m_cnt] = 32'h0;
      if (m_cnt == 15) m_busy = 1'b0;
      m_cnt = (m_cnt + 1) % 16;
    end else begin
      if (re) begin
        old_w = m_mem[raddress];
        new_w = old_w;
        if (we && (raddress == waddress))
          for (int i = 0; i < 4; i++) if (be[i]) new_w[8*i +: 8] = din[8*i +: 8];
        ma_dout = old_w; ma_rv = 1'b1;
        mb_s1d  = new_w; mb_s1v = 1'b1;
      end
      if (we)
        for (int i = 0; i < 4; i++) if (be[i]) m_mem[waddress][8*i +: 8] = din[8*i +: 8];
      if (clear) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("busy_a",   {31'h0, busy_a},   {31'h0, m_busy});
    check_eq("busy_b",   {31'h0, busy_b},   {31'h0, m_busy});
    check_eq("rvalid_a", {31'h0, rvalid_a}, {31'h0, ma_rv});
    check_eq("rvalid_b", {31'h0, rvalid_b}, {31'h0, mb_rv});
    check_eq("dout_a",   dout_a, ma_dout);
    check_eq("dout_b",   dout_b, mb_dout);
  endtask

  // drive inputs just after a falling edge, step the model, compare at the next falling edge
  task automatic tick(input logic c, input logic w, input logic [3:0] b, input logic [3:0] wa,
                      input logic [31:0] d, input logic r, input logic [3:0] ra);
    clear = c; we = w; be = b; waddress = wa; din = d; re = r; raddress = ra;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_dout_a",   dout_a, 32'h0);
    check_eq("rst_dout_b",   dout_b, 32'h0);
    check_eq("rst_rvalid_a", {31'h0, rvalid_a}, 32'h0);
    check_eq("rst_rvalid_b", {31'h0, rvalid_b}, 32'h0);
    check_eq("rst_busy",     {31'h0, busy_a}, 32'h1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // counts cycles with busy high, starting right after the sequencer begins
  task automatic busy_len(input string tag);
    int n;
    n = 0;
    while (busy_a && n < 40) begin
      n++;
      idle();
    end
    check_eq(tag, n, 32'd16);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; we = 1'b0; be = 4'h0; waddress = 4'h0;
    din = 32'h0; re = 1'b0; raddress = 4'h0;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'hDEAD_0000 + i;
    #2;
    apply_reset();
    check_eq("length_a", length_a, 32'd16);
    check_eq("length_b", length_b, 32'd16);
    busy_len("busy_len_reset");

    for (int a = 0; a < 16; a++) tick(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
    idle(); idle();

    // byte enables
    tick(1'b0, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    check_eq("byte_en_a", dout_a, 32'hAA22CC44);
    idle();
    check_eq("byte_en_b", dout_b, 32'hAA22CC44);

    // read during write
    tick(1'b0, 1'b1, 4'hF, 4'd5, 32'h0, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'h3, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
    check_eq("rdw_old", dout_a, 32'h00000000);
    idle();
    check_eq("rdw_new", dout_b, 32'h0000FFFF);

    // output register latency
    tick(1'b0, 1'b1, 4'hF, 4'd1, 32'd10, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'hF, 4'd2, 32'd20, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'hF, 4'd3, 32'd30, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1);
    check_eq("oreg_c1_rv", {31'h0, rvalid_b}, 32'h0);
    tick(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);
    check_eq("oreg_c2", dout_b, 32'd10);
    tick(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    check_eq("oreg_c3", dout_b, 32'd20);
    idle();
    check_eq("oreg_c4", dout_b, 32'd30);
    idle();
    check_eq("oreg_hold", dout_b, 32'd30);
    check_eq("oreg_hold_rv", {31'h0, rvalid_b}, 32'h0);

    // clear request with port traffic held high; clear re-pulsed while busy
    tick(1'b0, 1'b1, 4'hF, 4'd7, 32'h12345678, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    for (int k = 0; k < 16; k++) begin
      check_eq("clr_busy_on", {31'h0, busy_a}, 32'h1);
      tick(k == 14, 1'b1, 4'hF, 4'd7, 32'h55, 1'b1, 4'd7);
      check_eq("clr_no_rv", {31'h0, rvalid_a}, 32'h0);
    end
    check_eq("clr_busy_off", {31'h0, busy_a}, 32'h0);
    tick(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd7);
    check_eq("clr_addr7", dout_a, 32'h0);
    idle();

    // in-flight read survives a clear start, then reset mid-clear
    tick(1'b0, 1'b1, 4'hF, 4'd9, 32'h00001234, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd9);
    tick(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    check_eq("inflight_b", dout_b, 32'h00001234);
    for (int k = 0; k < 7; k++) idle();
    apply_reset();
    busy_len("busy_len_midclear");

    // randomized traffic
    for (int k = 0; k < 400; k++)
      tick(($urandom % 60) == 0, 1'($urandom), 4'($urandom), 4'($urandom_range(0, 15)),
           $urandom, 1'($urandom), 4'($urandom_range(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
